// File: rtl/hwpe_stream_tcdm_load_unit.sv
// hwpe_stream_tcdm_load_unit: credit-limited TCDM read issuer with a registered response FIFO.
// Addresses become TCDM reads, and in-order responses are streamed out.
module hwpe_stream_tcdm_load_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               clear_i,
   input  logic                               enable_i,
   input  logic                               addr_valid_i,
   output logic                               addr_ready_o,
   input  logic [31:0]                        addr_data_i,
   output logic                               tcdm_req_o,
   input  logic                               tcdm_gnt_i,
   output logic [31:0]                        tcdm_add_o,
   output logic                               tcdm_wen_o,
   output logic [DATA_WIDTH/8-1:0]            tcdm_be_o,
   output logic [DATA_WIDTH-1:0]              tcdm_data_o,
   input  logic                               tcdm_r_valid_i,
   input  logic [DATA_WIDTH-1:0]              tcdm_r_data_i,
   output logic                               stream_valid_o,
   input  logic                               stream_ready_i,
   output logic [DATA_WIDTH-1:0]              stream_data_o,
   output logic [DATA_WIDTH/8-1:0]            stream_strb_o,
   output logic                               busy_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    outstanding_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   logic [CW-1:0]         r_inflight, r_discard, r_count;
   logic [AW-1:0]         r_wptr, r_rptr;
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [CW:0]           w_used;
   logic                  w_gnt, w_cnt, w_disc, w_push, w_pop;
   // credits cover both words in flight and words already buffered, so the FIFO can never overflow
   assign w_used         = {1'b0, r_inflight} + {1'b0, r_count};
   assign tcdm_req_o     = ~rst_i & addr_valid_i & enable_i & ~clear_i & (w_used < (CW+1)'(FIFO_DEPTH));
   assign w_gnt          = tcdm_req_o & tcdm_gnt_i;
   assign addr_ready_o   = w_gnt;
   assign tcdm_add_o     = addr_data_i;
   assign tcdm_wen_o     = 1'b1;
   assign tcdm_be_o      = '1;
   assign tcdm_data_o    = '0;
   assign w_disc         = tcdm_r_valid_i & (r_discard != '0);
   assign w_cnt          = tcdm_r_valid_i & (r_discard == '0) & (r_inflight != '0);
   assign w_push         = w_cnt & ~clear_i;
   assign stream_valid_o = r_count != '0;
   assign w_pop          = stream_valid_o & stream_ready_i & ~clear_i;
   assign stream_data_o  = r_mem[r_rptr];
   assign stream_strb_o  = '1;
   assign outstanding_o  = r_inflight;
   assign busy_o         = (r_inflight != '0) | (r_discard != '0) | (r_count != '0);
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_inflight <= '0;
         r_discard  <= '0;
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else if (clear_i) begin
         r_inflight <= '0;
         r_discard  <= r_inflight - CW'(w_cnt);
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         r_inflight <= r_inflight + CW'(w_gnt) - CW'(w_cnt);
         r_discard  <= r_discard - CW'(w_disc);
         r_count    <= r_count + CW'(w_push) - CW'(w_pop);
         r_wptr     <= r_wptr + AW'(w_push);
         r_rptr     <= r_rptr + AW'(w_pop);
      end
   end
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr] <= tcdm_r_data_i;
   end
endmodule

// File: doc/hwpe_stream_tcdm_load_unit.md
HWPE_STREAM_TCDM_LOAD_UNIT -- requirements
Module: hwpe_stream_tcdm_load_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of TCDM read data and output stream data.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: response buffer entries and maximum in-flight plus buffered words (power of two, at least 2).
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port clear_i, input, 1 bit: synchronous soft clear.
REQ-006 SHALL have port enable_i, input, 1 bit: permits new TCDM requests.
REQ-007 SHALL have ports addr_valid_i (input, 1), addr_ready_o (output, 1) and addr_data_i (input, 32): incoming address stream from the address generator.
REQ-008 SHALL have ports tcdm_req_o (output, 1), tcdm_gnt_i (input, 1), tcdm_add_o (output, 32), tcdm_wen_o (output, 1), tcdm_be_o (output, DATA_WIDTH/8) and tcdm_data_o (output, DATA_WIDTH): TCDM request channel.
REQ-009 SHALL have ports tcdm_r_valid_i (input, 1) and tcdm_r_data_i (input, DATA_WIDTH): TCDM response channel.
REQ-010 SHALL have ports stream_valid_o (output, 1), stream_ready_i (input, 1), stream_data_o (output, DATA_WIDTH) and stream_strb_o (output, DATA_WIDTH/8): outgoing data stream.
REQ-011 SHALL have ports busy_o (output, 1) and outstanding_o (output, clog2(FIFO_DEPTH+1)): status flags.

Function
REQ-012 Request issue: tcdm_req_o SHALL be addr_valid_i AND enable_i AND NOT clear_i AND (inflight_q + fifo_count_q < FIFO_DEPTH), combinationally.
REQ-013 The request fields SHALL be: tcdm_add_o = addr_data_i; tcdm_wen_o = 1 (read); tcdm_be_o = all ones; tcdm_data_o = 0.
REQ-014 addr_ready_o SHALL be tcdm_req_o AND tcdm_gnt_i; an address is consumed only on a grant.
REQ-015 Once asserted, tcdm_req_o SHALL NOT depend on tcdm_gnt_i (no combinational loop); a held address remains presented until granted.
REQ-016 The in-flight counter SHALL add 1 on a grant and subtract 1 on each counted response; simultaneous events SHALL leave it unchanged.
REQ-017 Responses SHALL arrive in order, one or more cycles after the grant; the block SHALL never back-pressure tcdm_r_valid_i.
REQ-018 A counted response SHALL push tcdm_r_data_i into the FIFO; the credit rule in REQ-012 guarantees the FIFO never overflows, including a push and a pop in the same cycle while full.
REQ-019 The FIFO SHALL be registered with no fall-through: a response in cycle N is visible on stream_valid_o/stream_data_o at cycle N+1 at the earliest.
REQ-020 stream_valid_o SHALL equal (fifo_count_q != 0); stream_data_o SHALL be the FIFO head; a pop occurs on stream_valid_o AND stream_ready_i; stream_strb_o SHALL be all ones.
REQ-021 Output data SHALL hold stable while stream_valid_o=1 and stream_ready_i=0.
REQ-022 enable_i=0 SHALL block only new requests; responses SHALL still be captured and the FIFO SHALL still drain.
REQ-023 On clear_i, at the next edge: FIFO emptied; inflight := 0; discard_q := inflight_q - (counted response this cycle ? 1 : 0).
REQ-024 While discard_q > 0, each tcdm_r_valid_i SHALL decrement discard_q, SHALL NOT be pushed, and SHALL NOT decrement inflight.
REQ-025 Any tcdm_r_valid_i with inflight_q = 0 and discard_q = 0 SHALL be ignored.
REQ-026 outstanding_o SHALL equal inflight_q; busy_o SHALL be (inflight_q != 0) OR (discard_q != 0) OR (fifo_count_q != 0).

Reset
REQ-027 While rst_i=1, asynchronously: inflight, discard and FIFO pointers/count SHALL be 0; stream_valid_o=0, tcdm_req_o=0, addr_ready_o=0, busy_o=0 and outstanding_o=0.
REQ-028 Reset asserted mid-transaction SHALL discard all state; responses arriving after the release of rst_i with counters at 0 SHALL be ignored per REQ-025.

Verification
REQ-029 Back-to-back flow: addresses 0x100, 0x104, 0x108 with gnt=1, 1-cycle response latency and stream_ready_i=1 -> three requests in consecutive cycles, and data out in the same order 2 cycles after each grant.
REQ-030 Output stall: stream_ready_i=0, FIFO_DEPTH=4, continuous addresses -> exactly 4 grants, then tcdm_req_o=0 with outstanding_o + FIFO count = 4; one pop -> exactly one further request.
REQ-031 Grant stall: gnt=0 for 3 cycles with addr 0x200 -> tcdm_req_o held at 1 with tcdm_add_o=0x200 and addr_ready_o=0; gnt=1 -> one request only.
REQ-032 Clear with 2 in flight: clear_i asserted, then 2 responses -> neither reaches the stream; busy_o falls after the 2nd response; the next address is served normally.
REQ-033 enable_i=0 with 1 word in flight -> no new request; the response is still delivered on the stream.
REQ-034 Async reset mid-burst -> all outputs reach their REQ-027 values without a clock edge; a stray tcdm_r_valid_i after the release of rst_i produces no stream_valid_o.
